// File: rtl/ex_muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide unit owning HI/LO, fed from the ID/EX register.
// Build option MULDIV_EARLY_EXIT_EN: multiplies stop once the remaining multiplier bits are all zero.
module ex_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iValid,
   input  logic [5:0]       iFun,
   input  logic [WIDTH-1:0] iRegOut1,
   input  logic [WIDTH-1:0] iRegOut2,
   output logic             oStall,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oHi,
   output logic [WIDTH-1:0] oLo,
   output logic [WIDTH-1:0] oMfData
);
   // state | meaning
   // IDLE  | waiting for an op; MTHI/MTLO write and MFHI/MFLO read here
   // BUSY  | one shift-add or restoring-divide step per cycle
   // FIX   | sign correction and HI/LO write; oDone pulses the next cycle

   localparam logic [5:0] FUN_MFHI  = 6'h10;
   localparam logic [5:0] FUN_MTHI  = 6'h11;
   localparam logic [5:0] FUN_MFLO  = 6'h12;
   localparam logic [5:0] FUN_MTLO  = 6'h13;
   localparam logic [5:0] FUN_MULT  = 6'h18;
   localparam logic [5:0] FUN_MULTU = 6'h19;
   localparam logic [5:0] FUN_DIV   = 6'h1A;
   localparam logic [5:0] FUN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } stateT;

   stateT state, stateNext;

   logic [CNT_W-1:0]   cnt;
   logic               isMul;
   logic               divZero;
   logic               negRes;
   logic               negRem;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   opB;
   logic [WIDTH-1:0]   accHi;
   logic [WIDTH-1:0]   accLo;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               doneReg;
   logic               busyReg;

   logic               funMul, funDiv, funMove, funInSet, signedOp;
   logic               signA, signB, rtZero, startOp, lastIter, earlyExit;
   logic [WIDTH-1:0]   absA, absB;
   logic [2*WIDTH-1:0] accSum, prodFix;
   logic [WIDTH:0]     remShift, remDiff;

   assign funMul   = (iFun == FUN_MULT) || (iFun == FUN_MULTU);
   assign funDiv   = (iFun == FUN_DIV)  || (iFun == FUN_DIVU);
   assign funMove  = (iFun == FUN_MFHI) || (iFun == FUN_MFLO) ||
                     (iFun == FUN_MTHI) || (iFun == FUN_MTLO);
   assign funInSet = funMul | funDiv | funMove;
   assign signedOp = (iFun == FUN_MULT) || (iFun == FUN_DIV);

   // Magnitudes are iterated on; signs are reapplied in FIX
   assign signA   = signedOp & iRegOut1[WIDTH-1];
   assign signB   = signedOp & iRegOut2[WIDTH-1];
   assign absA    = signA ? (~iRegOut1 + 1'b1) : iRegOut1;
   assign absB    = signB ? (~iRegOut2 + 1'b1) : iRegOut2;
   assign rtZero  = (iRegOut2 == '0);
   assign startOp = (state == IDLE) & iValid & (funMul | funDiv);

   assign lastIter = (cnt == CNT_W'(WIDTH - 1));
   assign accSum   = {accHi, accLo} + mcand;
   assign remShift = {accHi, accLo[WIDTH-1]};
   assign remDiff  = remShift - {1'b0, opB};
   assign prodFix  = negRes ? (~{accHi, accLo} + 1'b1) : {accHi, accLo};

`ifdef MULDIV_EARLY_EXIT_EN
   // opB still holds the bit consumed this cycle, so look only above it
   assign earlyExit = isMul & (opB[WIDTH-1:1] == '0);
`else
   assign earlyExit = 1'b0;
`endif

   assign oStall = iValid & funInSet & busyReg;
   assign oBusy  = busyReg;
   assign oDone  = doneReg;
   assign oHi    = hiReg;
   assign oLo    = loReg;

   always_comb begin
      oMfData = '0;
      if (iValid && iFun == FUN_MFHI) begin
         oMfData = hiReg;
      end else if (iValid && iFun == FUN_MFLO) begin
         oMfData = loReg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (startOp) begin
               stateNext = (funDiv && rtZero) ? FIX : BUSY;
            end
         end
         BUSY: begin
            if (lastIter || earlyExit) begin
               stateNext = FIX;
            end
         end
         FIX:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         isMul   <= 1'b0;
         divZero <= 1'b0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         mcand   <= '0;
         opB     <= '0;
         accHi   <= '0;
         accLo   <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         doneReg <= 1'b0;
         busyReg <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         busyReg <= (stateNext != IDLE);
         case (state)
            IDLE: begin
               if (startOp) begin
                  cnt     <= '0;
                  isMul   <= funMul;
                  divZero <= funDiv & rtZero;
                  negRes  <= signA ^ signB;
                  negRem  <= signA;
                  mcand   <= funMul ? {{WIDTH{1'b0}}, absA} : '0;
                  opB     <= absB;
                  // A zero divisor skips BUSY; the raw dividend rides in accHi to FIX
                  accHi   <= (funDiv && rtZero) ? iRegOut1 : '0;
                  accLo   <= funMul ? '0 : absA;
               end else if (iValid && iFun == FUN_MTHI) begin
                  hiReg <= iRegOut1;
               end else if (iValid && iFun == FUN_MTLO) begin
                  loReg <= iRegOut1;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (isMul) begin
                  if (opB[0]) begin
                     {accHi, accLo} <= accSum;
                  end
                  mcand <= mcand << 1;
                  opB   <= opB >> 1;
               end else if (!remDiff[WIDTH]) begin
                  accHi <= remDiff[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], 1'b1};
               end else begin
                  accHi <= remShift[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               doneReg <= 1'b1;
               if (divZero) begin
                  hiReg <= accHi;
                  loReg <= '1;
               end else if (isMul) begin
                  {hiReg, loReg} <= prodFix;
               end else begin
                  loReg <= negRes ? (~accLo + 1'b1) : accLo;
                  hiReg <= negRem ? (~accHi + 1'b1) : accHi;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random ops against an arithmetic reference model.
// Honours MULDIV_EARLY_EXIT_EN when computing expected multiply latency.
module tb_ex_muldiv_unit;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_OTHER = 6'h20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iValid = 1'b0;
   logic [5:0]  iFun = 6'h0;
   logic [31:0] iRegOut1 = 32'h0;
   logic [31:0] iRegOut2 = 32'h0;
   logic        oStall, oBusy, oDone;
   logic [31:0] oHi, oLo, oMfData;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .iValid   (iValid),
      .iFun     (iFun),
      .iRegOut1 (iRegOut1),
      .iRegOut2 (iRegOut2),
      .oStall   (oStall),
      .oBusy    (oBusy),
      .oDone    (oDone),
      .oHi      (oHi),
      .oLo      (oLo),
      .oMfData  (oMfData)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Edges after the accept edge until oDone is visible
   function automatic int mul_latency(input logic [5:0] fun, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
      logic [31:0] m;
      int          top;
      m = (fun == F_MULT && b[31]) ? (32'h0 - b) : b;
      top = 1;
      for (int i = 0; i < 32; i++) if (m[i]) top = i + 1;
      return top + 1;
`else
      return (fun == F_MULT || fun == F_MULTU) ? 33 : 0;
`endif
   endfunction

   function automatic void model(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output int lat);
      longint      sa, sb, q, r;
      logic [63:0] p;
      hi = 32'h0; lo = 32'h0; lat = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (fun)
         F_MULTU: begin
            p = {32'h0, a} * {32'h0, b};
            hi = p[63:32]; lo = p[31:0]; lat = mul_latency(fun, b);
         end
         F_MULT: begin
            q = sa * sb;
            p = 64'(q);
            hi = p[63:32]; lo = p[31:0]; lat = mul_latency(fun, b);
         end
         F_DIV: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF; lat = 1;
            end else begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0]; lat = 33;
            end
         end
         F_DIVU: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF; lat = 1;
            end else begin
               lo = a / b; hi = a % b; lat = 33;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic wait_done(output int edges, output bit seen);
      edges = 0;
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (oDone === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [5:0] fun, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eHi, eLo;
      int          eLat, edges;
      bit          seen;
      model(fun, a, b, eHi, eLo, eLat);
      @(negedge clk);
      iValid = 1'b1; iFun = fun; iRegOut1 = a; iRegOut2 = b;
      #1;
      checks++;
      if (oStall !== 1'b0) begin
         errors++; $display("FAIL accept_stall fun=%h: got %b expected 0", fun, oStall);
      end
      @(posedge clk);
      #1;
      iValid = 1'b0; iFun = 6'h0;
      checks++;
      if (oBusy !== 1'b1) begin
         errors++; $display("FAIL busy_after_accept fun=%h: got %b expected 1", fun, oBusy);
      end
      wait_done(edges, seen);
      checks++;
      if (!seen) begin
         errors++; $display("FAIL done_timeout fun=%h a=%h b=%h: no oDone within 60 edges", fun, a, b);
      end else if (edges != eLat) begin
         errors++; $display("FAIL latency fun=%h a=%h b=%h: got %0d edges expected %0d", fun, a, b, edges, eLat);
      end
      checks++;
      if (oHi !== eHi) begin
         errors++; $display("FAIL hi fun=%h a=%h b=%h: got %h expected %h", fun, a, b, oHi, eHi);
      end
      checks++;
      if (oLo !== eLo) begin
         errors++; $display("FAIL lo fun=%h a=%h b=%h: got %h expected %h", fun, a, b, oLo, eLo);
      end
      @(negedge clk);
      checks++;
      if (oDone !== 1'b0 || oBusy !== 1'b0) begin
         errors++; $display("FAIL done_pulse fun=%h: got done=%b busy=%b expected 0 0", fun, oDone, oBusy);
      end
   endtask

   task automatic test_reset();
      iValid = 1'b1; iFun = F_MFHI;
      #1;
      checks++;
      if (oBusy !== 1'b0 || oDone !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", oBusy, oDone);
      end
      checks++;
      if (oHi !== 32'h0 || oLo !== 32'h0) begin
         errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0 0", oHi, oLo);
      end
      checks++;
      if (oStall !== 1'b0 || oMfData !== 32'h0) begin
         errors++; $display("FAIL reset_stall_mf: got stall=%b mf=%h expected 0 0", oStall, oMfData);
      end
      repeat (2) @(negedge clk);
      iValid = 1'b0; iFun = 6'h0;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op(F_MULTU, 32'hFFFF_FFFF, 32'h2);
      run_op(F_MULT,  32'hFFFF_FFFD, 32'h5);
      run_op(F_DIV,   32'hFFFF_FFF9, 32'h2);
      run_op(F_DIVU,  32'h7,         32'h0);
      run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op(F_DIV,   32'hFFFF_FFFB, 32'h0);
      run_op(F_MULT,  32'h8000_0000, 32'h8000_0000);
      run_op(F_DIVU,  32'hFFFF_FFFF, 32'h1);
   endtask

   task automatic test_move();
      logic [31:0] v;
      v = $urandom;
      @(negedge clk);
      iValid = 1'b1; iFun = F_MTLO; iRegOut1 = 32'h1234;
      #1;
      checks++;
      if (oStall !== 1'b0) begin
         errors++; $display("FAIL mtlo_stall: got %b expected 0", oStall);
      end
      @(negedge clk);
      checks++;
      if (oLo !== 32'h1234) begin
         errors++; $display("FAIL mtlo_value: got %h expected %h", oLo, 32'h1234);
      end
      iFun = F_MTHI; iRegOut1 = v;
      @(negedge clk);
      checks++;
      if (oHi !== v || oLo !== 32'h1234) begin
         errors++; $display("FAIL mthi_value: got hi=%h lo=%h expected %h %h", oHi, oLo, v, 32'h1234);
      end
      iFun = F_MFHI;
      #1;
      checks++;
      if (oMfData !== v || oStall !== 1'b0) begin
         errors++; $display("FAIL mfhi_read: got %h stall=%b expected %h 0", oMfData, oStall, v);
      end
      iFun = F_MFLO;
      #1;
      checks++;
      if (oMfData !== 32'h1234) begin
         errors++; $display("FAIL mflo_read: got %h expected %h", oMfData, 32'h1234);
      end
      iFun = F_OTHER;
      #1;
      checks++;
      if (oMfData !== 32'h0 || oStall !== 1'b0) begin
         errors++; $display("FAIL other_fun: got mf=%h stall=%b expected 0 0", oMfData, oStall);
      end
      @(negedge clk);
      iValid = 1'b0; iFun = 6'h0;
   endtask

   task automatic test_stall();
      logic [31:0] eHi, eLo;
      int          eLat, edges, badStall;
      bit          seen;
      model(F_MULT, 32'hFFFF_FFFD, 32'h0000_0005, eHi, eLo, eLat);
      @(negedge clk);
      iValid = 1'b1; iFun = F_MULT; iRegOut1 = 32'hFFFF_FFFD; iRegOut2 = 32'h5;
      @(posedge clk);
      #1;
      iFun = F_OTHER;
      #1;
      checks++;
      if (oStall !== 1'b0) begin
         errors++; $display("FAIL other_fun_busy_stall: got %b expected 0", oStall);
      end
      iFun = F_MFHI;
      edges = 0; seen = 1'b0; badStall = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (oDone === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (oStall !== 1'b1) badStall++;
      end
      checks++;
      if (!seen || edges != eLat) begin
         errors++; $display("FAIL stall_latency: got seen=%b edges=%0d expected 1 %0d", seen, edges, eLat);
      end
      checks++;
      if (badStall != 0) begin
         errors++; $display("FAIL stall_held: got %0d unstalled busy cycles expected 0", badStall);
      end
      checks++;
      if (oStall !== 1'b0 || oMfData !== eHi) begin
         errors++; $display("FAIL mfhi_after_done: got stall=%b mf=%h expected 0 %h", oStall, oMfData, eHi);
      end
      @(negedge clk);
      iValid = 1'b0; iFun = 6'h0;
   endtask

   task automatic test_busy_ignore();
      logic [31:0] a, b, eHi, eLo;
      int          eLat, edges;
      bit          seen;
      a = $urandom; b = $urandom | 32'h8000_0000;
      model(F_MULTU, a, b, eHi, eLo, eLat);
      @(negedge clk);
      iValid = 1'b1; iFun = F_MULTU; iRegOut1 = a; iRegOut2 = b;
      @(posedge clk);
      #1;
      iFun = F_MTLO; iRegOut1 = 32'hDEAD_BEEF;
      wait_done(edges, seen);
      iValid = 1'b0; iFun = 6'h0;
      checks++;
      if (!seen || oLo !== eLo || oHi !== eHi) begin
         errors++; $display("FAIL mt_while_busy: got seen=%b hi=%h lo=%h expected 1 %h %h", seen, oHi, oLo, eHi, eLo);
      end
      @(negedge clk);
      checks++;
      if (oLo !== eLo) begin
         errors++; $display("FAIL mt_after_done: got lo=%h expected %h", oLo, eLo);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, eHi, eLo;
      int          eLat, edges;
      bit          seen;
      a = $urandom; b = $urandom_range(1, 1000);
      @(negedge clk);
      iValid = 1'b1; iFun = F_DIVU; iRegOut1 = a; iRegOut2 = b;
      @(posedge clk);
      #1;
      iValid = 1'b0;
      wait_done(edges, seen);
      a = $urandom; b = $urandom | 32'h8000_0000;
      model(F_MULTU, a, b, eHi, eLo, eLat);
      iValid = 1'b1; iFun = F_MULTU; iRegOut1 = a; iRegOut2 = b;
      #1;
      checks++;
      if (!seen || oStall !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got seen=%b stall=%b expected 1 0", seen, oStall);
      end
      @(posedge clk);
      #1;
      iValid = 1'b0; iFun = 6'h0;
      wait_done(edges, seen);
      checks++;
      if (!seen || edges != eLat) begin
         errors++; $display("FAIL b2b_latency: got seen=%b edges=%0d expected 1 %0d", seen, edges, eLat);
      end
      checks++;
      if (oHi !== eHi || oLo !== eLo) begin
         errors++; $display("FAIL b2b_result: got %h_%h expected %h_%h", oHi, oLo, eHi, eLo);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit doneSeen;
      @(negedge clk);
      iValid = 1'b1; iFun = F_MTHI; iRegOut1 = 32'hA5A5_0001;
      @(negedge clk);
      iFun = F_MTLO; iRegOut1 = 32'h5A5A_0002;
      @(negedge clk);
      iFun = F_MULTU; iRegOut1 = $urandom; iRegOut2 = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      iValid = 1'b0; iFun = 6'h0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (oBusy !== 1'b0 || oHi !== 32'h0 || oLo !== 32'h0) begin
         errors++; $display("FAIL mid_reset: got busy=%b hi=%h lo=%h expected 0 0 0", oBusy, oHi, oLo);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      doneSeen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (oDone !== 1'b0 || oBusy !== 1'b0) doneSeen = 1'b1;
      end
      checks++;
      if (doneSeen) begin
         errors++; $display("FAIL mid_reset_no_done: got activity after abort expected none");
      end
      run_op(F_MULTU, $urandom, 32'hFFFF_FFFF);
   endtask

   task automatic test_random();
      logic [5:0]  funs [4];
      logic [31:0] specials [6];
      logic [31:0] a, b;
      funs[0] = F_MULT; funs[1] = F_MULTU; funs[2] = F_DIV; funs[3] = F_DIVU;
      specials[0] = 32'h0;         specials[1] = 32'h1;
      specials[2] = 32'hFFFF_FFFF; specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h2;
      for (int n = 0; n < 40; n++) begin
         a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
         run_op(funs[$urandom_range(0, 3)], a, b);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_move();
      test_stall();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
